// File: rtl/id_reader.sv
// id_reader
//   Active reader for a constant device-ID source. On a request it samples
//   the parallel ID bus until the value has been identical for SAMPLES
//   consecutive cycles, latches it, compares it against EXPECTED_ID and
//   shifts the latched ID out MSB-first. Completion, mismatch and timeout
//   are flagged toward the host/debug path.
//
// Parameters
//   EXPECTED_ID : value the latched ID is compared against
//   SAMPLES     : consecutive identical samples for a valid read (1..15)
//   TIMEOUT     : sampling cycles before abort (SAMPLES..255)
//
// Ports
//   i_clk          clock, all state updates on rising edge
//   i_rst          synchronous active-high reset
//   i_id_in[7:0]   parallel ID bus
//   i_start        read request, accepted only when idle
//   o_busy         high while sampling or shifting
//   o_done         one-cycle completion pulse
//   o_match        latched ID equals EXPECTED_ID
//   o_err_timeout  stability not reached within TIMEOUT cycles
//   o_id_latched   last successfully latched ID
//   o_ser_out      serial ID bit, MSB first (0 when not valid)
//   o_ser_valid    o_ser_out carries a valid bit
module id_reader #(
  parameter logic [7:0]  EXPECTED_ID = 8'hB1,
  parameter int unsigned SAMPLES     = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_id_in,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_match,
  output logic       o_err_timeout,
  output logic [7:0] o_id_latched,
  output logic       o_ser_out,
  output logic       o_ser_valid
);

  localparam logic [3:0] LP_SAMPLES = 4'(SAMPLES);
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [3:0] r_stab;
  logic [7:0] r_cyc;
  logic [7:0] r_sample;
  logic [7:0] r_shreg;
  logic [2:0] r_bit;
  logic [7:0] r_id_latched;
  logic       r_match;
  logic       r_err;

  logic [3:0] w_stab_next;
  logic [7:0] w_cyc_next;
  logic       w_stable;
  logic       w_timeout;

  // Stability tracking. A zero stability count marks the first sampling
  // edge of a read, so a sample left over from an earlier read never
  // extends the run.
  always_comb begin
    w_cyc_next  = r_cyc + 8'd1;
    w_stab_next = ((r_stab == 4'd0) || (i_id_in != r_sample)) ? 4'd1
                                                              : r_stab + 4'd1;
    w_stable    = (r_state == S_SAMPLE) && (w_stab_next == LP_SAMPLES);
    // Stability wins when both conditions occur on the same edge.
    w_timeout   = (r_state == S_SAMPLE) && !w_stable &&
                  (w_cyc_next == LP_TIMEOUT);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_next = S_SAMPLE;
      S_SAMPLE: begin
        if (w_stable)       w_state_next = S_SHIFT;
        else if (w_timeout) w_state_next = S_FIN;
      end
      S_SHIFT:  if (r_bit == 3'd7) w_state_next = S_FIN;
      S_FIN:    w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy        = (r_state == S_SAMPLE) || (r_state == S_SHIFT);
    o_done        = (r_state == S_FIN);
    o_ser_valid   = (r_state == S_SHIFT);
    o_ser_out     = (r_state == S_SHIFT) && r_shreg[7];
    o_match       = r_match;
    o_err_timeout = r_err;
    o_id_latched  = r_id_latched;
  end

  // Datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stab       <= '0;
      r_cyc        <= '0;
      r_sample     <= '0;
      r_shreg      <= '0;
      r_bit        <= '0;
      r_id_latched <= '0;
      r_match      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_match <= 1'b0;
            r_err   <= 1'b0;
            r_stab  <= '0;
            r_cyc   <= '0;
          end
        end
        S_SAMPLE: begin
          r_cyc    <= w_cyc_next;
          r_stab   <= w_stab_next;
          r_sample <= i_id_in;
          if (w_stable) begin
            r_id_latched <= i_id_in;
            r_match      <= (i_id_in == EXPECTED_ID);
            r_shreg      <= i_id_in;
            r_bit        <= '0;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_match <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_shreg <= {r_shreg[6:0], 1'b0};
          r_bit   <= r_bit + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_reader.sv
// Self-checking bench for id_reader: directed scenarios plus randomized
// ID sequences, checked against a window-based reference model.
module tb_id_reader;

  localparam logic [7:0] EXP_ID = 8'hB1;
  localparam int         SAMP   = 4;
  localparam int         TMO    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] id_in;
  logic       busy, done, match, err_to, ser_out, ser_valid;
  logic [7:0] id_latched;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] seq [0:39];
  logic [7:0] m_latched;
  logic       m_match;
  logic       m_err;

  always #5 clk = ~clk;

  id_reader #(
    .EXPECTED_ID(EXP_ID),
    .SAMPLES    (SAMP),
    .TIMEOUT    (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_id_in      (id_in),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_match      (match),
    .o_err_timeout(err_to),
    .o_id_latched (id_latched),
    .o_ser_out    (ser_out),
    .o_ser_valid  (ser_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_busy, input logic e_done,
                         input logic e_valid, input logic e_sout);
    chk({tag, " busy"},      32'(busy),       32'(e_busy));
    chk({tag, " done"},      32'(done),       32'(e_done));
    chk({tag, " ser_valid"}, 32'(ser_valid),  32'(e_valid));
    chk({tag, " ser_out"},   32'(ser_out),    32'(e_sout));
    chk({tag, " match"},     32'(match),      32'(m_match));
    chk({tag, " err"},       32'(err_to),     32'(m_err));
    chk({tag, " latched"},   32'(id_latched), 32'(m_latched));
  endtask

  // Reference: the read latches at the first sampling edge k (1-based)
  // whose SAMP-long window of samples ending at k is all equal, provided
  // k <= TMO; 0 means timeout.
  function automatic int find_latch();
    for (int k = SAMP; k <= TMO; k++) begin
      bit ok = 1'b1;
      for (int m = k - SAMP + 1; m <= k; m++)
        if (seq[m-1] != seq[k-1]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 40; i++) seq[i] = v;
  endtask

  task automatic fill_random();
    logic [7:0] prev;
    prev = EXP_ID;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0)
        prev = ($urandom_range(1) == 1) ? EXP_ID : 8'($urandom);
      seq[i] = prev;
    end
  endtask

  // Called at a negedge; returns at a negedge. abort_j > 0 asserts reset
  // right after the check following sampling-relative edge abort_j.
  task automatic run_read(input string tag, input bit hold, input bit repulse,
                          input int abort_j);
    int         L, D;
    logic [7:0] lid;
    logic       e_valid, e_sout;
    string      t;
    L   = find_latch();
    D   = (L != 0) ? L + 8 : TMO;
    lid = (L != 0) ? seq[L-1] : 8'h00;
    start = 1'b1;
    id_in = seq[0];
    @(posedge clk);
    for (int j = 0; j <= D + 1; j++) begin
      @(negedge clk);
      if (j == 0) begin
        m_match = 1'b0;
        m_err   = 1'b0;
      end
      if (L != 0 && j == L) begin
        m_latched = lid;
        m_match   = (lid == EXP_ID);
      end
      if (L == 0 && j == TMO) m_err = 1'b1;
      e_valid = (L != 0) && (j >= L) && (j < L + 8);
      e_sout  = e_valid ? lid[7 - (j - L)] : 1'b0;
      t = $sformatf("%s j%0d", tag, j);
      chk_all(t, (j < D), (j == D), e_valid, e_sout);
      if (abort_j > 0 && j == abort_j) begin
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        m_latched = 8'h00;
        m_match   = 1'b0;
        m_err     = 1'b0;
        chk_all({tag, " abort"}, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        return;
      end
      if (j <= D) begin
        id_in = seq[j];
        start = hold ? 1'b1 : (repulse ? 1'($urandom_range(1)) : 1'b0);
      end
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    id_in     = 8'h00;
    m_latched = 8'h00;
    m_match   = 1'b0;
    m_err     = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset has priority over a simultaneous start
    start = 1'b1;
    @(negedge clk);
    chk_all("rst_prio", 1'b0, 1'b0, 1'b0, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    fill_const(8'hB1);
    run_read("b1", 1'b0, 1'b0, 0);
    chk("b1 final latched", 32'(id_latched), 32'h0000_00B1);

    fill_const(8'h3C);
    run_read("3c", 1'b0, 1'b1, 0);

    for (int i = 0; i < 40; i++) seq[i] = (i % 2 == 1) ? 8'hB0 : 8'hB1;
    run_read("toggle", 1'b0, 1'b1, 0);

    fill_const(8'hB1);
    seq[1] = 8'h00;
    run_read("glitch", 1'b0, 1'b0, 0);

    fill_const(8'hB1);
    run_read("abort", 1'b0, 1'b0, SAMP + 3);
    @(negedge clk);
    chk_all("post_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    fill_const(8'h3C);
    run_read("after_abort", 1'b0, 1'b0, 0);

    fill_const(8'($urandom));
    run_read("hold1", 1'b1, 1'b0, 0);
    fill_const(8'hB1);
    run_read("hold2", 1'b0, 1'b0, 0);

    for (int r = 0; r < 20; r++) begin
      fill_random();
      run_read($sformatf("rnd%0d", r), 1'b0, 1'($urandom_range(1)), 0);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
